// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//
// Memory + writeback stage sitting directly behind execute. It accepts one
// instruction at a time. Three cases are handled:
//   - Non-memory instructions retire one cycle after they are accepted.
//   - Loads and stores go out over a valid/ready data-memory request port.
//     Loads then wait on the response port. The loaded byte or halfword is
//     taken from its lane and extended before it is written back.
//   - Misaligned or illegal accesses are dropped and flagged on misalign_err.
// in_ready is low whenever an access is in flight, which stalls execute.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   in_valid/in_ready   handshake with execute (in_ready=1 only in IDLE)
//   in_rd, in_wb_en     destination register and its write enable
//   in_mem_read/write   load / store qualifiers
//   in_funct3           RISC-V load/store size code
//   in_alu_result       ALU result or effective address
//   in_rs2_val          store data
//   dmem_req_*          data-memory request (word address, lane mask, data)
//   dmem_resp_*         data-memory response (full aligned word)
//   wb_en/wb_rd/wb_data register-file writeback port (wb_en is a pulse)
//   misalign_err        one-cycle pulse for a misaligned or illegal access
// ---------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_wb_en,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic [2:0]        in_funct3,
    input  logic [XLEN-1:0]   in_alu_result,
    input  logic [XLEN-1:0]   in_rs2_val,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic              dmem_req_write,
    output logic [XLEN-1:0]   dmem_req_addr,
    output logic [XLEN-1:0]   dmem_req_wdata,
    output logic [3:0]        dmem_req_mask,
    input  logic              dmem_resp_valid,
    input  logic [XLEN-1:0]   dmem_resp_data,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              misalign_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]        r_state;
    logic [REG_AW-1:0] r_rd;
    logic              r_wb_en;
    logic [2:0]        r_funct3;
    logic [1:0]        r_lane;

    logic              w_accept;
    logic              w_is_mem;
    logic              w_legal;
    logic [3:0]        w_mask;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_lane_word;
    logic [XLEN-1:0]   w_load_data;

    assign in_ready = (r_state == ST_IDLE);
    assign w_accept = in_valid && in_ready;
    assign w_is_mem = in_mem_read || in_mem_write;

    // Alignment / legality of the incoming access. Unsigned sizes exist
    // only for loads, so funct3 4/5 with a store are rejected here.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so
        // no path through the case can leave it unassigned (latch inference).
        w_legal = 1'b0;
        case (in_funct3)
            3'd0:    w_legal = 1'b1;
            3'd4:    w_legal = !in_mem_write;
            3'd1:    w_legal = !in_alu_result[0];
            3'd5:    w_legal = !in_mem_write && !in_alu_result[0];
            3'd2:    w_legal = (in_alu_result[1:0] == 2'b00);
            default: w_legal = 1'b0;
        endcase
    end

    // Byte-enable mask and lane-replicated store data. The memory picks the
    // right lane using the mask, so the data is copied into every lane.
    always_comb begin
        w_mask  = 4'b0000;
        w_wdata = '0;
        case (in_funct3[1:0])
            2'b00: begin
                w_mask  = 4'b0001 << in_alu_result[1:0];
                w_wdata = {(XLEN/8){in_rs2_val[7:0]}};
            end
            2'b01: begin
                w_mask  = 4'b0011 << in_alu_result[1:0];
                w_wdata = {(XLEN/16){in_rs2_val[15:0]}};
            end
            2'b10: begin
                w_mask  = 4'b1111;
                w_wdata = in_rs2_val;
            end
            default: begin
                w_mask  = 4'b0000;
                w_wdata = '0;
            end
        endcase
        if (!in_mem_write) begin
            w_wdata = '0;
        end
    end

    // Shift the addressed lane down to bit 0, then extend it by size.
    // For word loads the lane offset is always 0, so no shift happens.
    assign w_lane_word = dmem_resp_data >> {r_lane, 3'b000};

    always_comb begin
        w_load_data = w_lane_word;
        case (r_funct3)
            3'd0:    w_load_data = {{(XLEN-8){w_lane_word[7]}},   w_lane_word[7:0]};
            3'd4:    w_load_data = {{(XLEN-8){1'b0}},             w_lane_word[7:0]};
            3'd1:    w_load_data = {{(XLEN-16){w_lane_word[15]}}, w_lane_word[15:0]};
            3'd5:    w_load_data = {{(XLEN-16){1'b0}},            w_lane_word[15:0]};
            default: w_load_data = w_lane_word;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_rd           <= '0;
            r_wb_en        <= 1'b0;
            r_funct3       <= '0;
            r_lane         <= '0;
            dmem_req_valid <= 1'b0;
            dmem_req_write <= 1'b0;
            dmem_req_addr  <= '0;
            dmem_req_wdata <= '0;
            dmem_req_mask  <= '0;
            wb_en          <= 1'b0;
            wb_rd          <= '0;
            wb_data        <= '0;
            misalign_err   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register samples pre-edge values regardless of order.
            // wb_en and misalign_err are pulses: cleared unless set below.
            wb_en        <= 1'b0;
            misalign_err <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (!w_is_mem) begin
                            wb_en   <= in_wb_en && (in_rd != '0);
                            wb_rd   <= in_rd;
                            wb_data <= in_alu_result;
                        end else if (!w_legal) begin
                            misalign_err <= 1'b1;
                        end else begin
                            r_state        <= ST_REQ;
                            r_rd           <= in_rd;
                            r_wb_en        <= in_wb_en;
                            r_funct3       <= in_funct3;
                            r_lane         <= in_alu_result[1:0];
                            dmem_req_valid <= 1'b1;
                            dmem_req_write <= in_mem_write;
                            dmem_req_addr  <= {in_alu_result[XLEN-1:2], 2'b00};
                            dmem_req_wdata <= w_wdata;
                            dmem_req_mask  <= w_mask;
                        end
                    end
                end

                ST_REQ: begin
                    // Request fields stay frozen until the handshake.
                    if (dmem_req_ready) begin
                        dmem_req_valid <= 1'b0;
                        r_state        <= dmem_req_write ? ST_IDLE : ST_RESP;
                    end
                end

                ST_RESP: begin
                    if (dmem_resp_valid) begin
                        wb_en   <= r_wb_en && (r_rd != '0);
                        wb_rd   <= r_rd;
                        wb_data <= w_load_data;
                        r_state <= ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
